// File: rtl/subt_16bit_pkg.sv
// Shared constants and types for the registered 16-bit subtractor.
package subt_16bit_pkg;

    localparam int SUB_WIDTH = 16;

    typedef logic [SUB_WIDTH-1:0] word_t;

endpackage

// File: rtl/subt_16bit_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module subt_16bit_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/subt_16bit.sv
// Registered WIDTH-bit ripple-borrow subtractor: difference = a - b - cin.
module subt_16bit
    import subt_16bit_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             out_valid
);

    logic [WIDTH:0]   bw;
    logic [WIDTH-1:0] d;

    assign bw[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        subt_16bit_full_subtractor u_fs (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (bw[i]),
            .d    (d[i]),
            .bout (bw[i+1])
        );
    end

    // Result registers hold their value while no new operands arrive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            difference <= '0;
            borrow     <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                difference <= d;
                borrow     <= bw[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_subt_16bit.sv
// Directed and randomized checks for subt_16bit.
module tb_subt_16bit;
    import subt_16bit_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  in_valid;
    word_t a;
    word_t b;
    logic  cin;
    word_t difference;
    logic  borrow;
    logic  out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    subt_16bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .difference (difference),
        .borrow     (borrow),
        .out_valid  (out_valid)
    );

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input word_t x,
                         input word_t y, input logic c);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input word_t d_exp,
                              input logic b_exp, input logic v_exp);
        chk({tag, ".diff"}, difference, d_exp);
        chk({tag, ".borrow"}, {15'd0, borrow}, {15'd0, b_exp});
        chk({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v_exp});
    endtask

    task automatic vec(input string tag, input word_t x, input word_t y,
                       input logic c, input word_t d_exp, input logic b_exp);
        drive(1'b1, 1'b1, x, y, c);
        expect_out(tag, d_exp, b_exp, 1'b1);
    endtask

    initial begin
        logic [16:0] r17;
        word_t       ra;
        word_t       rb;
        logic        rc;

        rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h0001; cin = 1'b0;
        drive(1'b0, 1'b1, 16'h1234, 16'h0001, 1'b0);
        drive(1'b0, 1'b1, 16'h1234, 16'h0001, 1'b0);
        expect_out("reset", 16'h0000, 1'b0, 1'b0);

        vec("zero",    16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vec("basic",   16'h0008, 16'h0002, 1'b0, 16'h0006, 1'b0);
        vec("cin",     16'h0008, 16'h0002, 1'b1, 16'h0005, 1'b0);
        vec("ripple",  16'h0030, 16'h000F, 1'b0, 16'h0021, 1'b0);
        vec("ripple2", 16'h0008, 16'h0004, 1'b0, 16'h0004, 1'b0);
        vec("wrap",    16'h0002, 16'h0FFB, 1'b0, 16'hF007, 1'b1);
        vec("wrap1",   16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
        vec("wrapmax", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        vec("equal",   16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0);
        vec("eqcin",   16'hA5A5, 16'hA5A5, 1'b1, 16'hFFFF, 1'b1);
        vec("top",     16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0);

        drive(1'b1, 1'b0, 16'h0000, 16'h0005, 1'b1);
        expect_out("hold0", 16'hFFFE, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
        expect_out("hold1", 16'hFFFE, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
        expect_out("hold2", 16'hFFFE, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0);
        expect_out("rst_mid", 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra  = word_t'($urandom);
            rb  = word_t'($urandom);
            rc  = 1'($urandom_range(1, 0));
            r17 = {1'b0, ra} - {1'b0, rb} - {16'd0, rc};
            vec("rand", ra, rb, rc, r17[15:0], r17[16]);
        end

        drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("idle.valid", {15'd0, out_valid}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
